mult_div_unit: RTL and testbench

//  Iterative multi-cycle multiply/divide unit; producer side of the HI/LO register interface.
//  - Accepts MULT/MULTU/DIV/DIVU operations from the control unit.
//  - Returns product, quotient and remainder with one-cycle mult_ready/div_ready strobes.
//  - Strobes are consumed directly by the HI/LO register file.

---
 rtl/mult_div_unit_if.sv | 36 +++
 rtl/mult_div_unit.sv | 155 +++++++++++++++
 tb/tb_mult_div_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake/result bundle between the control unit (master) and mult_div_unit (slave).
// MDU_DIV0_FAST_EN adds the div_by_zero flag to the bundle.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic                 start_mult;
  logic                 start_div;
  logic                 is_signed;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 busy;
  logic                 mult_ready;
  logic                 div_ready;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     quotient;
  logic [2*WIDTH-1:0]   remainder;
`ifdef MDU_DIV0_FAST_EN
  logic                 div_by_zero;

  modport master (
    output start_mult, start_div, is_signed, op_a, op_b,
    input  busy, mult_ready, div_ready, product, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start_mult, start_div, is_signed, op_a, op_b,
    output busy, mult_ready, div_ready, product, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start_mult, start_div, is_signed, op_a, op_b,
    input  busy, mult_ready, div_ready, product, quotient, remainder
  );
  modport slave (
    input  start_mult, start_div, is_signed, op_a, op_b,
    output busy, mult_ready, div_ready, product, quotient, remainder
  );
`endif
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider feeding the HI/LO register file.
// Optional MDU_DIV0_FAST_EN: single-step divide-by-zero with a div_by_zero flag.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            CLK,
  input logic            RST,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t             state, next_state;
  logic [CW-1:0]      cnt;
  logic               last_iter;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0]   mplier, quo, prem, divisor;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     shifted, diff;
  logic               res_neg, rem_neg, op_mult;
  logic               div_step_en;
`ifdef MDU_DIV0_FAST_EN
  logic               div0_fast;
`endif

  assign last_iter = (cnt == CW'(WIDTH-1));
  assign abs_a     = (bus.is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign abs_b     = (bus.is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
  assign shifted   = {prem, quo[WIDTH-1]};
  assign diff      = shifted - {1'b0, divisor};
  assign bus.busy  = (state != IDLE);

`ifdef MDU_DIV0_FAST_EN
  assign div_step_en = !div0_fast;
`else
  assign div_step_en = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start_mult)     next_state = MULT;
        else if (bus.start_div) next_state = DIV;
      end
      MULT: if (last_iter) next_state = FIX;
      DIV: begin
`ifdef MDU_DIV0_FAST_EN
        if (div0_fast || last_iter) next_state = FIX;
`else
        if (last_iter) next_state = FIX;
`endif
      end
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt            <= '0;
      mcand          <= '0;
      acc            <= '0;
      mplier         <= '0;
      quo            <= '0;
      prem           <= '0;
      divisor        <= '0;
      res_neg        <= 1'b0;
      rem_neg        <= 1'b0;
      op_mult        <= 1'b0;
      bus.mult_ready <= 1'b0;
      bus.div_ready  <= 1'b0;
      bus.product    <= '0;
      bus.quotient   <= '0;
      bus.remainder  <= '0;
`ifdef MDU_DIV0_FAST_EN
      div0_fast       <= 1'b0;
      bus.div_by_zero <= 1'b0;
`endif
    end else begin
      bus.mult_ready <= 1'b0;
      bus.div_ready  <= 1'b0;
`ifdef MDU_DIV0_FAST_EN
      bus.div_by_zero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.start_mult || bus.start_div) begin
            op_mult <= bus.start_mult;
            cnt     <= '0;
            mcand   <= {{WIDTH{1'b0}}, abs_a};
            mplier  <= abs_b;
            acc     <= '0;
            quo     <= abs_a;
            prem    <= '0;
            divisor <= abs_b;
            res_neg <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            rem_neg <= bus.is_signed & bus.op_a[WIDTH-1];
`ifdef MDU_DIV0_FAST_EN
            // Fast path preloads the final raw result and suppresses sign correction
            div0_fast <= !bus.start_mult && (bus.op_b == '0);
            if (!bus.start_mult && (bus.op_b == '0)) begin
              quo     <= '1;
              prem    <= bus.op_a;
              res_neg <= 1'b0;
              rem_neg <= 1'b0;
            end
`endif
          end
        end
        MULT: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        DIV: begin
          if (div_step_en) begin
            // Borrow out of the trial subtraction means restore (quotient bit 0)
            if (!diff[WIDTH]) begin
              prem <= diff[WIDTH-1:0];
              quo  <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              prem <= shifted[WIDTH-1:0];
              quo  <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (op_mult) begin
            bus.product    <= res_neg ? -acc : acc;
            bus.mult_ready <= 1'b1;
          end else begin
            bus.quotient  <= res_neg ? -quo : quo;
            bus.remainder <= {{WIDTH{1'b0}}, (rem_neg ? -prem : prem)};
            bus.div_ready <= 1'b1;
`ifdef MDU_DIV0_FAST_EN
            bus.div_by_zero <= div0_fast;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_p = '0;
  logic [31:0] exp_q = '0;
  logic [63:0] exp_r = '0;
  logic        exp_dbz = 1'b0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the arithmetic meaning of each operation
  task automatic model(input bit is_mult, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] p, output logic [31:0] q, output logic [63:0] r,
                       output logic dbz);
    longint sa, sb, qq, rr;
    sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    p   = '0;
    q   = '0;
    r   = '0;
    dbz = 1'b0;
    if (is_mult) begin
      p = sgn ? 64'(sa * sb) : ({32'b0, a} * {32'b0, b});
    end else if (b == 32'h0) begin
      r = {32'b0, a};
`ifdef MDU_DIV0_FAST_EN
      q   = 32'hFFFF_FFFF;
      dbz = 1'b1;
`else
      q = (sgn && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
`endif
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[31:0];
      r  = {32'b0, rr[31:0]};
    end
  endtask

  task automatic apply_stimulus(input bit do_mult, input bit do_div, input bit sgn,
                                input logic [31:0] a, input logic [31:0] b, input bit poke_busy);
    bit          as_mult;
    int          lat;
    int          want_lat;
    logic [63:0] p, r;
    logic [31:0] q;
    logic        dbz;
    as_mult = do_mult;
    model(as_mult, sgn, a, b, p, q, r, dbz);
    want_lat = 33;
`ifdef MDU_DIV0_FAST_EN
    if (!as_mult && b == 32'h0) want_lat = 2;
`endif
    if (as_mult) exp_p = p;
    else begin
      exp_q   = q;
      exp_r   = r;
    end
    exp_dbz = as_mult ? 1'b0 : dbz;

    bus.start_mult = do_mult;
    bus.start_div  = do_div;
    bus.is_signed  = sgn;
    bus.op_a       = a;
    bus.op_b       = b;
    tick();
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.is_signed  = $urandom_range(0, 1);
    bus.op_a       = $urandom;
    bus.op_b       = $urandom;
    check_output("busy_after_start", 64'(bus.busy), 64'd1);

    lat = 0;
    while (!(bus.mult_ready || bus.div_ready) && lat < 60) begin
      if (poke_busy && lat == 1) begin
        bus.start_mult = 1'b1;
        bus.start_div  = 1'b1;
      end else begin
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
      end
      tick();
      lat++;
    end
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;

    check_output("latency", 64'(lat), 64'(want_lat));
    check_output("mult_ready", 64'(bus.mult_ready), 64'(as_mult));
    check_output("div_ready", 64'(bus.div_ready), 64'(!as_mult));
    check_output("busy_in_strobe", 64'(bus.busy), 64'd0);
    check_output("product", bus.product, exp_p);
    check_output("quotient", 64'(bus.quotient), 64'(exp_q));
    check_output("remainder", bus.remainder, exp_r);
`ifdef MDU_DIV0_FAST_EN
    check_output("div_by_zero", 64'(bus.div_by_zero), 64'(exp_dbz));
`endif

    tick();
    check_output("strobe_one_cycle", 64'({bus.mult_ready, bus.div_ready}), 64'd0);
    check_output("product_held", bus.product, exp_p);
    check_output("quotient_held", 64'(bus.quotient), 64'(exp_q));
  endtask

  initial begin
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.is_signed  = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    RST            = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    check_output("reset_busy", 64'(bus.busy), 64'd0);
    check_output("reset_strobes", 64'({bus.mult_ready, bus.div_ready}), 64'd0);
    check_output("reset_product", bus.product, 64'd0);
    check_output("reset_quotient", 64'(bus.quotient), 64'd0);
    check_output("reset_remainder", bus.remainder, 64'd0);

    apply_stimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_output("multu_max_const", bus.product, 64'hFFFF_FFFE_0000_0001);

    apply_stimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check_output("mult_neg_const", bus.product, 64'hFFFF_FFFF_FFFF_FFEB);

    apply_stimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_output("div_neg_q_const", 64'(bus.quotient), 64'h0000_0000_FFFF_FFFD);
    check_output("div_neg_r_const", bus.remainder, 64'h0000_0000_FFFF_FFFF);

    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_output("div_ovf_q_const", 64'(bus.quotient), 64'h0000_0000_8000_0000);

    apply_stimulus(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
    check_output("divu_q_const", 64'(bus.quotient), 64'd14);
    check_output("divu_r_const", bus.remainder, 64'd2);

    // Both starts together: multiply wins; busy-time starts get poked mid-operation
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'hFEDC_BA98, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0001_0001, 32'h0000_FFFF, 1'b1);

    // Reset in the middle of a divide
    bus.start_div = 1'b1;
    bus.is_signed = 1'b0;
    bus.op_a      = 32'd1000;
    bus.op_b      = 32'd3;
    tick();
    bus.start_div = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_output("no_strobe_before_reset", 64'(bus.div_ready), 64'd0);
    end
    RST = 1'b1;
    tick();
    RST   = 1'b0;
    exp_p = '0;
    exp_q = '0;
    exp_r = '0;
    check_output("midreset_busy", 64'(bus.busy), 64'd0);
    check_output("midreset_strobes", 64'({bus.mult_ready, bus.div_ready}), 64'd0);
    check_output("midreset_quotient", 64'(bus.quotient), 64'd0);
    check_output("midreset_remainder", bus.remainder, 64'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3, 1'b0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
    check_output("div0_q_const", 64'(bus.quotient), 64'h0000_0000_FFFF_FFFF);
    check_output("div0_r_const", bus.remainder, 64'd5);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      bit          m, sg;
      logic [31:0] a, b;
      m  = $urandom_range(0, 1);
      sg = $urandom_range(0, 1);
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      apply_stimulus(m, !m, sg, a, b, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
